main_fsm: RTL and testbench
===========================

Name: main_fsm

Overview:
- Moore state machine that sequences the multicycle ARM datapath: fetch, decode, then a memory, data-processing or branch path.
- Drives the datapath mux selects and the raw write strobes RegW, MemW, NextPC and Branch.
- The conditional-execution logic gates those strobes downstream; this block never sees the flags.
- Adds a memory-ready handshake so fetch and memory accesses can stall on a slow memory.

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEMRD/MEMWR hold until MemReady=1; when 0 MemReady is ignored (treated as 1).
- STATE_W, 4, width of the state register and of the DbgState port.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- Op  in  2  instruction Op field from the instruction register
- Funct  in  6  instruction Funct field (bit5 = immediate, bit0 = load/store L bit)
- MemReady  in  1  memory has completed the current access this cycle
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register
- ALUSrcA  out  2  ALU A select: 00 = Rn, 01 = PC
- ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = force ADD
- NextPC  out  1  raw PC update (PC+4)
- RegW  out  1  raw register write request
- MemW  out  1  raw memory write request
- Branch  out  1  raw branch request
- DbgState  out  STATE_W  current state encoding

Behaviour:
- State encodings, fixed:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=15
- Reset: state=FETCH asynchronously while reset=0. First rising edge after release is the first FETCH cycle, with FETCH outputs visible during reset.
- All outputs are a pure function of the current state (Moore); any field not listed for a state is 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1, ALUOp=0.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1, ALUOp=0.
  - UNKNOWN: all outputs 0.
- Stall gating while a wait-state is held (MEM_WAIT_EN=1 and MemReady=0):
  - FETCH: IRWrite and NextPC forced to 0; the strobes assert only in the cycle MemReady=1.
  - MEMWR: MemW stays 1 for the whole access.
- Transitions:
  - FETCH -> DECODE when MemReady (or MEM_WAIT_EN=0), else stay.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB when ready, else stay. MEMWB -> FETCH.
  - MEMWR -> FETCH when ready, else stay.
  - EXECUTER/EXECUTEI -> ALUWB -> FETCH. BRANCH -> FETCH. UNKNOWN -> FETCH.
  - Any illegal encoding -> FETCH next cycle.
- Latency without stalls:
  - LDR: 5 cycles (FETCH, DECODE, MEMADR, MEMRD, MEMWB).
  - STR: 4 cycles. Data-processing: 4 cycles. Branch: 3 cycles.
- Op/Funct are sampled only in DECODE and MEMADR; changes in other states have no effect.
- Reset asserted mid-instruction: immediate return to FETCH, all write strobes drop combinationally with the state; no partial write is completed.

Decomposition:
- Shared package holds:
  - state encoding localparams;
  - ALUSrcA/ALUSrcB/ResultSrc select constants;
  - Op codes (OP_DP=00, OP_MEM=01, OP_BR=10).
- One natural sub-module: main_fsm_outdec, the combinational state-to-control-word decoder, so the ROM-like table is reviewable in isolation.
- Next-state logic and the state register live in main_fsm.

Test Plan:
- Reset low for 3 cycles mid-MEMWB, then release -> DbgState=0 during reset; RegW=0 immediately on reset assertion; IRWrite=1, NextPC=1 in the first cycle after release.
- Op=00, Funct=6'b001000, MemReady=1 -> states 0,1,7,8,0; ALUOp=1 in EXECUTEI; RegW=1 only in ALUWB; exactly one NextPC pulse.
- Op=01, Funct[0]=1, MemReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 throughout MEMRD; RegW=1 with ResultSrc=01 only in MEMWB.
- Op=01, Funct[0]=0, MemReady low 1 cycle in FETCH -> IRWrite=0 then 1; MemW=1 for the single MEMWR cycle; back to FETCH.
- Op=10 -> states 0,1,9,0 with Branch=1, ALUSrcB=01 only in BRANCH. Op=11 -> states 0,1,15,0 with no write strobes.
- MEM_WAIT_EN=0, MemReady held 0 -> LDR still completes in 5 cycles.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle ARM main controller: state encodings,
// datapath select constants, instruction Op codes and the control word layout.
package main_fsm_pkg;

  // Fixed state encodings. They are visible on DbgState, so keep them stable.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd15
  } state_t;

  // ALU A operand select
  localparam logic [1:0] SRCA_RN = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;

  // ALU B operand select
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Instruction Op field classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // One control word per state; every field defaults to zero.
  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(13'd0);

  // States that wait for the memory to complete an access before moving on.
  function automatic logic is_wait_state(input state_t st);
    logic res;
    case (st)
      S_FETCH, S_MEMRD, S_MEMWR: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control-word decoder for the main controller.
// The only non-state input is the effective memory-ready, which holds back
// the instruction-register load and PC increment while a fetch is stalled.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Control word lookup table; unlisted fields stay at zero.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.ir_write   = mem_ready;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.next_pc    = mem_ready;
        ctrl.alu_op     = 1'b0;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RN;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b0;
      end
      S_MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        // Write strobe is held for the whole access, stalled or not.
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RN;
        ctrl.alu_src_b = SRCB_RM;
        ctrl.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RN;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RN;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURESULT;
        ctrl.branch     = 1'b1;
        ctrl.alu_op     = 1'b0;
      end
      S_UNKNOWN: begin
        ctrl = CTRL_IDLE;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Main controller of the multicycle ARM datapath. Moore machine sequencing
// fetch, decode and the memory / data-processing / branch paths, with an
// optional memory-ready handshake that stalls fetch and memory accesses.
// Write strobes are raw; condition-flag gating happens downstream.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               ALUOp,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic [STATE_W-1:0] DbgState
);

  state_t state_r;
  state_t next_s;
  logic   ready_s;
  ctrl_t  ctrl_s;
  logic   unused_funct_s;

  // Only the immediate bit and the load/store bit steer the sequence.
  assign unused_funct_s = ^Funct[4:1];

  // With the handshake disabled the memory is treated as always ready.
  assign ready_s = MEM_WAIT_EN ? MemReady : 1'b1;

  // State register; reset returns to FETCH immediately, dropping all strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state selection; Op/Funct only matter in DECODE and MEMADR.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (ready_s) next_s = S_DECODE;
        else         next_s = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_MEM: next_s = S_MEMADR;
          OP_DP: begin
            if (Funct[5]) next_s = S_EXECUTEI;
            else          next_s = S_EXECUTER;
          end
          OP_BR:   next_s = S_BRANCH;
          default: next_s = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        if (Funct[0]) next_s = S_MEMRD;
        else          next_s = S_MEMWR;
      end
      S_MEMRD: begin
        if (ready_s) next_s = S_MEMWB;
        else         next_s = S_MEMRD;
      end
      S_MEMWB:    next_s = S_FETCH;
      S_MEMWR: begin
        if (ready_s) next_s = S_FETCH;
        else         next_s = S_MEMWR;
      end
      S_EXECUTER: next_s = S_ALUWB;
      S_EXECUTEI: next_s = S_ALUWB;
      S_ALUWB:    next_s = S_FETCH;
      S_BRANCH:   next_s = S_FETCH;
      S_UNKNOWN:  next_s = S_FETCH;
      default:    next_s = S_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state     (state_r),
    .mem_ready (ready_s),
    .ctrl      (ctrl_s)
  );

  assign IRWrite   = ctrl_s.ir_write;
  assign AdrSrc    = ctrl_s.adr_src;
  assign ALUSrcA   = ctrl_s.alu_src_a;
  assign ALUSrcB   = ctrl_s.alu_src_b;
  assign ResultSrc = ctrl_s.result_src;
  assign ALUOp     = ctrl_s.alu_op;
  assign NextPC    = ctrl_s.next_pc;
  assign RegW      = ctrl_s.reg_w;
  assign MemW      = ctrl_s.mem_w;
  assign Branch    = ctrl_s.branch;
  assign DbgState  = STATE_W'(state_r);

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm. Instance a uses the memory handshake with
// random stalls; instance b has the handshake disabled and MemReady held low.
// The stimulus side expands each instruction into its expected per-cycle
// state list and pushes expectations; a negedge monitor pops and compares.
module tb_main_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [1:0] op_a, op_b;
  logic [5:0] funct_a, funct_b;
  logic       mr_a, mr_b;

  logic       irw_a, adr_a, aluop_a, npc_a, regw_a, memw_a, br_a;
  logic [1:0] srca_a, srcb_a, res_a;
  logic [3:0] dbg_a;
  logic       irw_b, adr_b, aluop_b, npc_b, regw_b, memw_b, br_b;
  logic [1:0] srca_b, srcb_b, res_b;
  logic [3:0] dbg_b;

  main_fsm #(.MEM_WAIT_EN(1'b1), .STATE_W(4)) dut_a (
    .clk(clk), .reset(reset_a), .Op(op_a), .Funct(funct_a), .MemReady(mr_a),
    .IRWrite(irw_a), .AdrSrc(adr_a), .ALUSrcA(srca_a), .ALUSrcB(srcb_a),
    .ResultSrc(res_a), .ALUOp(aluop_a), .NextPC(npc_a), .RegW(regw_a),
    .MemW(memw_a), .Branch(br_a), .DbgState(dbg_a)
  );

  main_fsm #(.MEM_WAIT_EN(1'b0), .STATE_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .Op(op_b), .Funct(funct_b), .MemReady(mr_b),
    .IRWrite(irw_b), .AdrSrc(adr_b), .ALUSrcA(srca_b), .ALUSrcB(srcb_b),
    .ResultSrc(res_b), .ALUOp(aluop_b), .NextPC(npc_b), .RegW(regw_b),
    .MemW(memw_b), .Branch(br_b), .DbgState(dbg_b)
  );

  typedef struct packed {
    logic [3:0]  state;
    logic [12:0] ctrl;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word as listed per state: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch}
  function automatic logic [12:0] exp_ctrl(input int st, input logic rdy);
    logic ir = 1'b0, adr = 1'b0, aluop = 1'b0, npc = 1'b0, regw = 1'b0, memw = 1'b0, br = 1'b0;
    logic [1:0] sa = 2'b00, sb = 2'b00, rs = 2'b00;
    case (st)
      0: begin ir = rdy; sa = 2'b01; sb = 2'b10; rs = 2'b10; npc = rdy; end
      1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      2: begin sb = 2'b01; end
      3: begin adr = 1'b1; end
      4: begin rs = 2'b01; regw = 1'b1; end
      5: begin adr = 1'b1; memw = 1'b1; end
      6: begin aluop = 1'b1; end
      7: begin sb = 2'b01; aluop = 1'b1; end
      8: begin regw = 1'b1; end
      9: begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
      default: begin end
    endcase
    return {ir, adr, sa, sb, rs, aluop, npc, regw, memw, br};
  endfunction

  // Drive one cycle of inputs, record the expectation, advance to the next cycle.
  task automatic drive_cycle(input bit b, input int st, input logic mr,
                             input logic [1:0] op, input logic [5:0] fn);
    exp_t e;
    e.state = st[3:0];
    if (b) begin
      op_b = op; funct_b = fn; mr_b = mr;
      e.ctrl = exp_ctrl(st, 1'b1);
      q_b.push_back(e);
    end else begin
      op_a = op; funct_a = fn; mr_a = mr;
      e.ctrl = exp_ctrl(st, mr);
      q_a.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Expand one instruction into cycles: its state path, plus stall cycles in wait states.
  task automatic run_instr(input bit b, input logic [1:0] op, input logic [5:0] funct,
                           input int fstall, input int mstall);
    int path[$];
    int n;
    logic mr;
    logic [1:0] o;
    logic [5:0] f;
    path.push_back(0);
    path.push_back(1);
    case (op)
      2'b01: begin
        path.push_back(2);
        if (funct[0]) begin path.push_back(3); path.push_back(4); end
        else          path.push_back(5);
      end
      2'b00: begin
        if (funct[5]) path.push_back(7); else path.push_back(6);
        path.push_back(8);
      end
      2'b10:   path.push_back(9);
      default: path.push_back(15);
    endcase
    foreach (path[i]) begin
      int s = path[i];
      bit samp = (s == 1) || (s == 2);
      if (!b && (s == 0 || s == 3 || s == 5)) begin
        n = (s == 0) ? fstall : mstall;
        for (int k = 0; k < n; k++) begin
          o = samp ? op : 2'($urandom);
          f = samp ? funct : 6'($urandom);
          drive_cycle(b, s, 1'b0, o, f);
        end
        mr = 1'b1;
      end else begin
        mr = b ? 1'b0 : 1'($urandom_range(0, 1));
      end
      o = samp ? op : 2'($urandom);
      f = samp ? funct : 6'($urandom);
      drive_cycle(b, s, mr, o, f);
    end
  endtask

  // Monitor: compare each presented output cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      check("a_state", {12'd0, dbg_a}, {12'd0, e.state});
      check("a_ctrl", {3'd0, irw_a, adr_a, srca_a, srcb_a, res_a, aluop_a, npc_a, regw_a, memw_a, br_a},
            {3'd0, e.ctrl});
    end
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      check("b_state", {12'd0, dbg_b}, {12'd0, e.state});
      check("b_ctrl", {3'd0, irw_b, adr_b, srca_b, srcb_b, res_b, aluop_b, npc_b, regw_b, memw_b, br_b},
            {3'd0, e.ctrl});
    end
  end

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00; funct_a = 6'd0; funct_b = 6'd0;
    mr_a = 1'b1; mr_b = 1'b0;
    @(posedge clk); #1;
    // Held in reset: FETCH outputs visible, state stays 0 despite ready.
    fork
      begin repeat (3) drive_cycle(1'b0, 0, 1'b1, 2'($urandom), 6'($urandom)); end
      begin repeat (3) drive_cycle(1'b1, 0, 1'b0, 2'($urandom), 6'($urandom)); end
    join
    reset_a = 1'b1; reset_b = 1'b1;

    fork
      begin
        // Directed cases on the stalling instance.
        run_instr(1'b0, 2'b00, 6'b001000, 0, 0);
        run_instr(1'b0, 2'b01, 6'b000001, 0, 2);
        run_instr(1'b0, 2'b01, 6'b000000, 1, 0);
        run_instr(1'b0, 2'b10, 6'($urandom), 0, 0);
        run_instr(1'b0, 2'b11, 6'($urandom), 0, 0);
        // LDR interrupted by reset in MEMWB.
        drive_cycle(1'b0, 0, 1'b1, 2'b00, 6'd0);
        drive_cycle(1'b0, 1, 1'b1, 2'b01, 6'b000001);
        drive_cycle(1'b0, 2, 1'b1, 2'b01, 6'b000001);
        drive_cycle(1'b0, 3, 1'b1, 2'b11, 6'b000000);
        mr_a = 1'b1;
        #1;
        check("pre_reset_state", {12'd0, dbg_a}, 16'd4);
        check("pre_reset_regw", {15'd0, regw_a}, 16'd1);
        reset_a = 1'b0;
        #1;
        check("reset_state", {12'd0, dbg_a}, 16'd0);
        check("reset_regw", {15'd0, regw_a}, 16'd0);
        check("reset_irwrite", {15'd0, irw_a}, 16'd1);
        check("reset_nextpc", {15'd0, npc_a}, 16'd1);
        @(posedge clk); #1;
        repeat (2) drive_cycle(1'b0, 0, 1'b1, 2'($urandom), 6'($urandom));
        reset_a = 1'b1;
        run_instr(1'b0, 2'b00, 6'b000000, 0, 0);
        // Random instruction mix with random stalls.
        for (int i = 0; i < 40; i++) begin
          run_instr(1'b0, 2'($urandom), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
      end
      begin
        // Handshake disabled: MemReady low never stalls.
        run_instr(1'b1, 2'b01, 6'b000001, 0, 0);
        for (int i = 0; i < 30; i++) begin
          run_instr(1'b1, 2'($urandom), 6'($urandom), 0, 0);
        end
      end
    join

    repeat (2) @(posedge clk);
    #1;
    check("a_queue_drained", 16'(q_a.size()), 16'd0);
    check("b_queue_drained", 16'(q_b.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
